life_seq_ctrl: RTL and testbench

//  Upstream sequencer for the life_cell array: drives each cell's write/val/enb.

---
 rtl/life_seq_ctrl_if.sv | 37 +++
 rtl/life_seq_ctrl.sv | 162 ++++++++++++++++
 tb/tb_life_seq_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/life_seq_ctrl_if.sv
// Command/data and cell-write bundle between a host and life_seq_ctrl.
// The host drives the master side; the sequencer sits on the slave side.
interface life_seq_ctrl_if #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int PER_W = 24
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    logic             clear;
    logic             load_start;
    logic             load_bit;
    logic             load_valid;
    logic             load_ready;
    logic             run;
    logic             step;
    logic [PER_W-1:0] period;
    logic [RW-1:0]    wr_row;
    logic [CW-1:0]    wr_col;
    logic             write;
    logic             val;
    logic             enb;
    logic [15:0]      gen_count;
    logic             busy;
    logic             load_done;

    modport master (
        output clear, load_start, load_bit, load_valid, run, step, period,
        input  load_ready, wr_row, wr_col, write, val, enb, gen_count, busy, load_done
    );

    modport slave (
        input  clear, load_start, load_bit, load_valid, run, step, period,
        output load_ready, wr_row, wr_col, write, val, enb, gen_count, busy, load_done
    );
endinterface

// File: rtl/life_seq_ctrl.sv
// Sequencer for the life_cell array: clears/loads the grid through per-cell
// write strobes and advances generations with one-cycle enb pulses.
//
// state | meaning
// IDLE  | waiting; commands sampled here (clear > load_start > step > run)
// CLEAR | writing 0 to one cell per cycle in raster order
// LOAD  | accepting serial pattern bits, one cell write per accepted bit
// RUN   | free-running enb pulses every max(period,1) cycles while run=1
// STEP  | single enb pulse in flight, back to IDLE next cycle
module life_seq_ctrl #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int PER_W = 24
) (
    input  logic           clk,
    input  logic           reset,
    life_seq_ctrl_if.slave bus
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, RUN, STEP} state_t;

    state_t           state, state_nx;
    logic [RW-1:0]    wr_row, wr_row_nx, ld_row, ld_row_nx;
    logic [CW-1:0]    wr_col, wr_col_nx, ld_col, ld_col_nx;
    logic [PER_W-1:0] cnt, cnt_nx, term;
    logic [15:0]      gen_count, gen_nx;
    logic             write, write_nx, val, val_nx, enb, enb_nx;
    logic             ready, ready_nx, done, done_nx, busy, busy_nx;

    // A period of 0 behaves like 1; >= keeps a live period decrease from overshooting.
    assign term = (bus.period == '0) ? '0 : bus.period - 1'b1;

    always_comb begin
        state_nx  = state;
        wr_row_nx = wr_row;
        wr_col_nx = wr_col;
        ld_row_nx = ld_row;
        ld_col_nx = ld_col;
        cnt_nx    = cnt;
        gen_nx    = gen_count;
        write_nx  = 1'b0;
        val_nx    = 1'b0;
        enb_nx    = 1'b0;
        ready_nx  = 1'b0;
        done_nx   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.clear) begin
                    state_nx  = CLEAR;
                    write_nx  = 1'b1;
                    wr_row_nx = '0;
                    wr_col_nx = '0;
                    gen_nx    = '0;
                end else if (bus.load_start) begin
                    state_nx  = LOAD;
                    ready_nx  = 1'b1;
                    ld_row_nx = '0;
                    ld_col_nx = '0;
                end else if (bus.step) begin
                    state_nx = STEP;
                    enb_nx   = 1'b1;
                end else if (bus.run) begin
                    state_nx = RUN;
                    cnt_nx   = '0;
                end
            end
            CLEAR: begin
                if (wr_row == ROW_LAST && wr_col == COL_LAST) begin
                    state_nx = IDLE;
                end else begin
                    write_nx = 1'b1;
                    if (wr_col == COL_LAST) begin
                        wr_col_nx = '0;
                        wr_row_nx = wr_row + 1'b1;
                    end else begin
                        wr_col_nx = wr_col + 1'b1;
                    end
                end
            end
            LOAD: begin
                ready_nx = 1'b1;
                if (bus.load_valid) begin
                    write_nx  = 1'b1;
                    val_nx    = bus.load_bit;
                    wr_row_nx = ld_row;
                    wr_col_nx = ld_col;
                    if (ld_row == ROW_LAST && ld_col == COL_LAST) begin
                        state_nx = IDLE;
                        ready_nx = 1'b0;
                        done_nx  = 1'b1;
                    end else if (ld_col == COL_LAST) begin
                        ld_col_nx = '0;
                        ld_row_nx = ld_row + 1'b1;
                    end else begin
                        ld_col_nx = ld_col + 1'b1;
                    end
                end
            end
            RUN: begin
                if (!bus.run) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt >= term) begin
                    enb_nx = 1'b1;
                    cnt_nx = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            STEP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (enb_nx) gen_nx = gen_count + 1'b1;
        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wr_row    <= '0;
            wr_col    <= '0;
            ld_row    <= '0;
            ld_col    <= '0;
            cnt       <= '0;
            gen_count <= '0;
            write     <= 1'b0;
            val       <= 1'b0;
            enb       <= 1'b0;
            ready     <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            wr_row    <= wr_row_nx;
            wr_col    <= wr_col_nx;
            ld_row    <= ld_row_nx;
            ld_col    <= ld_col_nx;
            cnt       <= cnt_nx;
            gen_count <= gen_nx;
            write     <= write_nx;
            val       <= val_nx;
            enb       <= enb_nx;
            ready     <= ready_nx;
            done      <= done_nx;
            busy      <= busy_nx;
        end
    end

    assign bus.wr_row     = wr_row;
    assign bus.wr_col     = wr_col;
    assign bus.write      = write;
    assign bus.val        = val;
    assign bus.enb        = enb;
    assign bus.load_ready = ready;
    assign bus.load_done  = done;
    assign bus.busy       = busy;
    assign bus.gen_count  = gen_count;
endmodule

// File: tb/tb_life_seq_ctrl.sv
// Directed bench for life_seq_ctrl: reset abort, clear, glider load, step,
// free-run at two periods, and clear/step collision.
module tb_life_seq_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [63:0] pat;

    always #5 clk = ~clk;

    life_seq_ctrl_if #(.ROWS(8), .COLS(8), .PER_W(24)) bus ();

    life_seq_ctrl #(.ROWS(8), .COLS(8), .PER_W(24)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Clear sequence, optionally with step raised alongside clear.
    task automatic do_clear(input logic with_step, input string tag);
        int writes = 0, enbs = 0, first_k = -1, last_k = -1, bad = 0;
        bus.clear = 1'b1;
        bus.step  = with_step;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            if (k == 0) begin
                bus.clear = 1'b0;
                bus.step  = 1'b0;
            end
            if (bus.enb) enbs++;
            if (bus.write) begin
                if (first_k < 0) first_k = k;
                last_k = k;
                if ({29'd0, bus.wr_row} != 32'(writes / 8) ||
                    {29'd0, bus.wr_col} != 32'(writes % 8) || bus.val != 1'b0) bad++;
                writes++;
            end
        end
        check_val({tag, "_writes"}, 32'(writes), 32'd64);
        check_val({tag, "_first"}, 32'(first_k), 32'd0);
        check_val({tag, "_last"}, 32'(last_k), 32'd63);
        check_val({tag, "_raster"}, 32'(bad), 32'd0);
        check_val({tag, "_enb"}, 32'(enbs), 32'd0);
        check_val({tag, "_gen"}, 32'(bus.gen_count), 32'd0);
        check_val({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int sent, widx, dones, enbs, overlap;
        pat        = '0;
        pat[1]     = 1'b1;
        pat[10]    = 1'b1;
        pat[16]    = 1'b1;
        pat[17]    = 1'b1;
        pat[18]    = 1'b1;
        bus.clear      = 1'b0;
        bus.load_start = 1'b0;
        bus.load_bit   = 1'b0;
        bus.load_valid = 1'b0;
        bus.run        = 1'b0;
        bus.step       = 1'b0;
        bus.period     = '0;
        reset          = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_val("rst_busy", 32'(bus.busy), 32'd0);
        check_val("rst_write", 32'(bus.write), 32'd0);
        check_val("rst_enb", 32'(bus.enb), 32'd0);
        check_val("rst_ready", 32'(bus.load_ready), 32'd0);
        check_val("rst_done", 32'(bus.load_done), 32'd0);
        check_val("rst_gen", 32'(bus.gen_count), 32'd0);

        // Reset in the middle of a load
        bus.load_start = 1'b1;
        @(negedge clk);
        bus.load_start = 1'b0;
        check_val("ld1_ready", 32'(bus.load_ready), 32'd1);
        check_val("ld1_busy", 32'(bus.busy), 32'd1);
        for (int i = 0; i < 5; i++) begin
            bus.load_valid = 1'b1;
            bus.load_bit   = pat[i];
            @(negedge clk);
        end
        check_val("ld1_write", 32'(bus.write), 32'd1);
        bus.load_valid = 1'b0;
        reset          = 1'b0;
        @(posedge clk);
        #1;
        check_val("abort_busy", 32'(bus.busy), 32'd0);
        check_val("abort_write", 32'(bus.write), 32'd0);
        check_val("abort_ready", 32'(bus.load_ready), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        do_clear(1'b0, "clr");

        // Glider load with load_valid toggling every cycle
        bus.load_start = 1'b1;
        sent  = 0;
        widx  = 0;
        dones = 0;
        for (int c = 0; c < 400 && widx < 64; c++) begin
            @(negedge clk);
            bus.load_start = 1'b0;
            if (bus.load_done) dones++;
            if (bus.write) begin
                check_val($sformatf("ld_row%0d", widx), 32'(bus.wr_row), 32'(widx / 8));
                check_val($sformatf("ld_col%0d", widx), 32'(bus.wr_col), 32'(widx % 8));
                check_val($sformatf("ld_val%0d", widx), 32'(bus.val), 32'(pat[6'(widx)]));
                check_val($sformatf("ld_done%0d", widx), 32'(bus.load_done), 32'(widx == 63));
                widx++;
            end
            bus.load_valid = (c % 2 == 1) && (sent < 64);
            bus.load_bit   = (sent < 64) ? pat[6'(sent)] : 1'b0;
            if (bus.load_valid && bus.load_ready) sent++;
        end
        bus.load_valid = 1'b0;
        check_val("ld_count", 32'(widx), 32'd64);
        @(negedge clk);
        check_val("ld_done_pulses", 32'(dones), 32'd1);
        check_val("ld_done_after", 32'(bus.load_done), 32'd0);
        check_val("ld_ready_after", 32'(bus.load_ready), 32'd0);
        check_val("ld_busy_after", 32'(bus.busy), 32'd0);

        // Three step commands
        enbs    = 0;
        overlap = 0;
        for (int n = 0; n < 3; n++) begin
            bus.step = 1'b1;
            @(negedge clk);
            bus.step = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (bus.enb) enbs++;
                if (bus.enb && bus.write) overlap++;
                @(negedge clk);
            end
        end
        check_val("step_enbs", 32'(enbs), 32'd3);
        check_val("step_gen", 32'(bus.gen_count), 32'd3);
        check_val("step_overlap", 32'(bus.enb && bus.write) + 32'(overlap), 32'd0);

        // Free run, period 4 then 0, then stop
        bus.period = 24'd4;
        bus.run    = 1'b1;
        enbs       = 0;
        for (int k = 0; k < 21; k++) begin
            @(negedge clk);
            if (bus.enb) enbs++;
        end
        check_val("run4_enbs", 32'(enbs), 32'd5);
        check_val("run4_last", 32'(bus.enb), 32'd1);
        bus.period = '0;
        enbs       = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.enb) enbs++;
        end
        check_val("run0_enbs", 32'(enbs), 32'd10);
        check_val("run_gen", 32'(bus.gen_count), 32'd18);
        bus.run = 1'b0;
        @(negedge clk);
        check_val("stop_enb", 32'(bus.enb), 32'd0);
        check_val("stop_busy", 32'(bus.busy), 32'd0);
        enbs = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.enb) enbs++;
        end
        check_val("stop_quiet", 32'(enbs), 32'd0);
        check_val("stop_gen", 32'(bus.gen_count), 32'd18);

        // clear wins over step
        do_clear(1'b1, "clrstep");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
